rv32i_cpu: RTL and testbench

Multicycle RV32I integer core with a single shared instruction/data memory port. It fetches, decodes and executes the RV32I base ISA (no CSRs, no interrupts) against a word-addressed synchronous RAM whose read data appears one cycle after the address is presented. It is the top-level processing element and connects directly to the 512×32 block-RAM model `ram`, which is addressed with `dir[10:2]`.

---
 rtl/rv32i_pkg.sv | 74 +++++++
 rtl/rv32i_alu.sv | 36 +++
 rtl/rv32i_cpu.sv | 216 +++++++++++++++++++++
 tb/tb_rv32i_cpu.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcodes, funct3 codes,
// FSM state encoding and ALU operation selection.
package rv32i_pkg;

  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  localparam logic [2:0] F3_LB   = 3'd0;
  localparam logic [2:0] F3_LH   = 3'd1;
  localparam logic [2:0] F3_LW   = 3'd2;
  localparam logic [2:0] F3_LBU  = 3'd4;
  localparam logic [2:0] F3_LHU  = 3'd5;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_LOAD_WB,
    ST_STORE_MERGE
  } state_e;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT,
    ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND
  } alu_op_e;

  // SUB only exists in register form; SRA/SRAI both use bit 30
  function automatic alu_op_e alu_sel(
    input logic [2:0] f3,
    input logic       b5,
    input logic       is_r
  );
    alu_op_e op;
    op = ALU_ADD;
    unique case (f3)
      F3_ADD:  op = (is_r && b5) ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = b5 ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      F3_AND:  op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv32i_alu.sv
// Combinational 32-bit ALU with branch-compare flags.
// Shift amounts use the low five bits of b_i.
module rv32i_alu
  import rv32i_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  alu_op_e     op_i,
  output logic [31:0] res_o,
  output logic        eq_o,
  output logic        lt_o,
  output logic        ltu_o
);

  assign eq_o  = (a_i == b_i);
  assign lt_o  = ($signed(a_i) < $signed(b_i));
  assign ltu_o = (a_i < b_i);

  always_comb begin
    res_o = '0;
    unique case (op_i)
      ALU_ADD:  res_o = a_i + b_i;
      ALU_SUB:  res_o = a_i - b_i;
      ALU_SLL:  res_o = a_i << b_i[4:0];
      ALU_SLT:  res_o = {31'b0, lt_o};
      ALU_SLTU: res_o = {31'b0, ltu_o};
      ALU_XOR:  res_o = a_i ^ b_i;
      ALU_SRL:  res_o = a_i >> b_i[4:0];
      ALU_SRA:  res_o = $signed(a_i) >>> b_i[4:0];
      ALU_OR:   res_o = a_i | b_i;
      ALU_AND:  res_o = a_i & b_i;
      default:  res_o = '0;
    endcase
  end

endmodule

// File: rtl/rv32i_cpu.sv
// Multicycle RV32I core on one shared synchronous memory port.
// Sub-word stores do a read-merge-write over two cycles.
module rv32i_cpu
  import rv32i_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic        hab_escritura,
  output logic [31:0] dir,
  output logic [31:0] dat_escritura,
  input  logic [31:0] dat_lectura
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] rf_q [32];
  logic        rf_we;
  logic [31:0] rf_wd;

  logic [6:0]  opc;
  logic [4:0]  rd;
  logic [2:0]  f3;
  assign opc = ir_q[6:0];
  assign rd  = ir_q[11:7];
  assign f3  = ir_q[14:12];

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7],
                  ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_u = {ir_q[31:12], 12'b0};
  assign imm_j = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12],
                  ir_q[20], ir_q[30:21], 1'b0};

  // Register operands are read from the word arriving in DECODE
  logic [4:0]  d_rs1, d_rs2;
  logic [31:0] rs1_v, rs2_v;
  assign d_rs1 = dat_lectura[19:15];
  assign d_rs2 = dat_lectura[24:20];
  assign rs1_v = (d_rs1 == 5'd0) ? '0 : rf_q[d_rs1];
  assign rs2_v = (d_rs2 == 5'd0) ? '0 : rf_q[d_rs2];

  alu_op_e     alu_op;
  logic [31:0] alu_b, alu_res;
  logic        eq, lt, ltu;
  assign alu_op = alu_sel(f3, ir_q[30], opc == OPC_OP);
  assign alu_b  = (opc == OPC_OP || opc == OPC_BRANCH)
                  ? b_q : imm_i;

  rv32i_alu u_alu (
    .a_i   (a_q),
    .b_i   (alu_b),
    .op_i  (alu_op),
    .res_o (alu_res),
    .eq_o  (eq),
    .lt_o  (lt),
    .ltu_o (ltu)
  );

  logic [31:0] mem_addr, pc4, jalr_sum;
  logic [1:0]  lane;
  assign mem_addr = a_q + ((opc == OPC_STORE) ? imm_s : imm_i);
  assign lane     = mem_addr[1:0];
  assign pc4      = pc_q + 32'd4;
  assign jalr_sum = a_q + imm_i;

  logic br_taken;
  always_comb begin
    br_taken = 1'b0;
    unique case (f3)
      F3_BEQ:  br_taken = eq;
      F3_BNE:  br_taken = !eq;
      F3_BLT:  br_taken = lt;
      F3_BGE:  br_taken = !lt;
      F3_BLTU: br_taken = ltu;
      F3_BGEU: br_taken = !ltu;
      default: br_taken = 1'b0;
    endcase
  end

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] ld_val, st_val;
  assign byte_v = dat_lectura[{lane, 3'b000} +: 8];
  assign half_v = lane[1] ? dat_lectura[31:16]
                          : dat_lectura[15:0];

  always_comb begin
    ld_val = dat_lectura;
    unique case (f3)
      F3_LB:   ld_val = {{24{byte_v[7]}}, byte_v};
      F3_LH:   ld_val = {{16{half_v[15]}}, half_v};
      F3_LBU:  ld_val = {24'b0, byte_v};
      F3_LHU:  ld_val = {16'b0, half_v};
      default: ld_val = dat_lectura;
    endcase
  end

  always_comb begin
    st_val = dat_lectura;
    if (f3 == F3_LB)
      st_val[{lane, 3'b000} +: 8] = b_q[7:0];
    else
      st_val[{lane[1], 4'b0000} +: 16] = b_q[15:0];
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    a_d           = a_q;
    b_d           = b_q;
    dir           = pc_q;
    hab_escritura = 1'b0;
    dat_escritura = '0;
    rf_we         = 1'b0;
    rf_wd         = '0;
    unique case (state_q)
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        ir_d    = dat_lectura;
        a_d     = rs1_v;
        b_d     = rs2_v;
        state_d = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        state_d = ST_FETCH;
        pc_d    = pc4;
        unique case (1'b1)
          (opc == OPC_OP),
          (opc == OPC_OP_IMM): begin
            rf_we = 1'b1;
            rf_wd = alu_res;
          end
          (opc == OPC_LUI): begin
            rf_we = 1'b1;
            rf_wd = imm_u;
          end
          (opc == OPC_AUIPC): begin
            rf_we = 1'b1;
            rf_wd = pc_q + imm_u;
          end
          (opc == OPC_JAL): begin
            rf_we = 1'b1;
            rf_wd = pc4;
            pc_d  = pc_q + imm_j;
          end
          (opc == OPC_JALR): begin
            rf_we = 1'b1;
            rf_wd = pc4;
            pc_d  = {jalr_sum[31:1], 1'b0};
          end
          (opc == OPC_BRANCH): begin
            if (br_taken) pc_d = pc_q + imm_b;
          end
          (opc == OPC_LOAD): begin
            dir     = mem_addr;
            pc_d    = pc_q;
            state_d = ST_LOAD_WB;
          end
          (opc == OPC_STORE): begin
            dir = mem_addr;
            if (f3 == F3_LW) begin
              hab_escritura = 1'b1;
              dat_escritura = b_q;
            end else begin
              pc_d    = pc_q;
              state_d = ST_STORE_MERGE;
            end
          end
          default: ;
        endcase
      end
      ST_LOAD_WB: begin
        dir     = mem_addr;
        rf_we   = 1'b1;
        rf_wd   = ld_val;
        pc_d    = pc4;
        state_d = ST_FETCH;
      end
      ST_STORE_MERGE: begin
        dir           = mem_addr;
        hab_escritura = 1'b1;
        dat_escritura = st_val;
        pc_d          = pc4;
        state_d       = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rf_we && rd != 5'd0) rf_q[rd] <= rf_wd;
  end

endmodule

// File: tb/tb_rv32i_cpu.sv
// Directed bench for rv32i_cpu with a 512x32 sync RAM model.
// Programs are hand-assembled; expected values are hand-computed.
module tb_rv32i_cpu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        hab_escritura;
  logic [31:0] dir, dat_escritura, dat_lectura;

  logic [31:0] mem [512];
  logic        ld_en = 1'b0;
  logic [8:0]  ld_a = '0;
  logic [31:0] ld_d = '0;

  int total = 0;
  int bad = 0;
  int unsigned wr_n = 0;
  logic [31:0] wr_a = '0, wr_d = '0;
  int unsigned wr0;
  logic [31:0] prog[$];

  localparam logic [6:0] OP  = 7'h33;
  localparam logic [6:0] OPI = 7'h13;
  localparam logic [6:0] LD  = 7'h03;
  localparam logic [31:0] LOOP = 32'h0000_006f;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  rv32i_cpu dut (
    .clk           (clk),
    .reset         (reset),
    .hab_escritura (hab_escritura),
    .dir           (dir),
    .dat_escritura (dat_escritura),
    .dat_lectura   (dat_lectura)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ld_en) mem[ld_a] <= ld_d;
    else if (hab_escritura) mem[dir[10:2]] <= dat_escritura;
    dat_lectura <= mem[dir[10:2]];
  end

  always @(negedge clk) begin
    if (hab_escritura) begin
      wr_n <= wr_n + 1;
      wr_a <= dir;
      wr_d <= dat_escritura;
    end
  end

  function automatic logic [31:0] ei(
    input logic [11:0] imm, input logic [4:0] rs1,
    input logic [2:0] f3, input logic [4:0] rd,
    input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] er(
    input logic [6:0] f7, input logic [4:0] rs2,
    input logic [4:0] rs1, input logic [2:0] f3,
    input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OP};
  endfunction

  function automatic logic [31:0] es(
    input logic [11:0] imm, input logic [4:0] rs2,
    input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] eb(
    input logic [12:0] imm, input logic [4:0] rs2,
    input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3,
            imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] ej(
    input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12],
            rd, 7'h6f};
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic poke(input int w, input logic [31:0] d);
    @(negedge clk);
    ld_a  = w[8:0];
    ld_d  = d;
    ld_en = 1'b1;
    @(posedge clk);
    #1 ld_en = 1'b0;
  endtask

  task automatic hold_reset();
    @(negedge clk);
    reset = 1'b0;
    #1 check("rst_now_hab", {31'b0, hab_escritura}, 32'd0);
  endtask

  task automatic load_prog();
    foreach (prog[i]) poke(i, prog[i]);
  endtask

  task automatic release_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_dir", dir, 32'd0);
      check("rst_hab", {31'b0, hab_escritura}, 32'd0);
      check("rst_dat", dat_escritura, 32'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    wr0 = wr_n;
    #1 check("rel_c1_dir", dir, 32'd0);
  endtask

  initial begin
    // ALU, x0 handling and word store/load
    prog = '{
      ei(12'h005, 5'd0, 3'd0, 5'd1, OPI),
      ei(12'hFFD, 5'd0, 3'd0, 5'd2, OPI),
      er(7'h00, 5'd2, 5'd1, 3'd0, 5'd3),
      er(7'h00, 5'd1, 5'd2, 3'd2, 5'd4),
      er(7'h00, 5'd1, 5'd2, 3'd3, 5'd5),
      ei(12'h401, 5'd2, 3'd5, 5'd6, OPI),
      ei(12'h007, 5'd0, 3'd0, 5'd0, OPI),
      er(7'h00, 5'd0, 5'd0, 3'd0, 5'd8),
      es(12'h100, 5'd3, 5'd0, 3'd2),
      ei(12'h100, 5'd0, 3'd2, 5'd7, LD),
      LOOP
    };
    hold_reset();
    load_prog();
    release_reset();
    for (int c = 2; c <= 4; c++) begin
      @(posedge clk);
      #1 check("boot_dir", dir, (c == 4) ? 32'd4 : 32'd0);
    end
    repeat (50) @(posedge clk);
    #1;
    check("x1", dut.rf_q[1], 32'd5);
    check("x2", dut.rf_q[2], 32'hFFFF_FFFD);
    check("add_x3", dut.rf_q[3], 32'd2);
    check("slt_x4", dut.rf_q[4], 32'd1);
    check("sltu_x5", dut.rf_q[5], 32'd0);
    check("srai_x6", dut.rf_q[6], 32'hFFFF_FFFE);
    check("x0_read", dut.rf_q[8], 32'd0);
    check("sw_count", wr_n - wr0, 32'd1);
    check("sw_dir", wr_a, 32'h100);
    check("sw_dat", wr_d, 32'd2);
    check("sw_mem", mem[64], 32'd2);
    check("lw_x7", dut.rf_q[7], 32'd2);

    // Sub-word store merge and sign/zero-extended loads
    prog = '{
      ei(12'h080, 5'd0, 3'd0, 5'd1, OPI),
      es(12'h101, 5'd1, 5'd0, 3'd0),
      ei(12'h101, 5'd0, 3'd0, 5'd2, LD),
      ei(12'h101, 5'd0, 3'd4, 5'd3, LD),
      ei(12'h102, 5'd0, 3'd1, 5'd4, LD),
      ei(12'h100, 5'd0, 3'd5, 5'd5, LD),
      ei(12'h100, 5'd0, 3'd1, 5'd6, LD),
      LOOP
    };
    hold_reset();
    load_prog();
    poke(64, 32'h1122_3344);
    release_reset();
    repeat (60) @(posedge clk);
    #1;
    check("sb_mem", mem[64], 32'h1122_8044);
    check("sb_count", wr_n - wr0, 32'd1);
    check("sb_dir", wr_a, 32'h101);
    check("lb_x2", dut.rf_q[2], 32'hFFFF_FF80);
    check("lbu_x3", dut.rf_q[3], 32'h0000_0080);
    check("lh_x4", dut.rf_q[4], 32'h0000_1122);
    check("lhu_x5", dut.rf_q[5], 32'h0000_8044);
    check("lh_neg_x6", dut.rf_q[6], 32'hFFFF_8044);

    // Branches and jumps
    prog = '{
      ei(12'h001, 5'd0, 3'd0, 5'd1, OPI),
      ei(12'h000, 5'd0, 3'd0, 5'd10, OPI),
      ei(12'h000, 5'd0, 3'd0, 5'd13, OPI),
      ei(12'h000, 5'd0, 3'd0, 5'd11, OPI),
      ei(12'h000, 5'd0, 3'd0, 5'd12, OPI),
      ei(12'h000, 5'd0, 3'd0, 5'd14, OPI),
      NOP,
      NOP,
      eb(13'h008, 5'd1, 5'd1, 3'd0),
      ei(12'h001, 5'd0, 3'd0, 5'd10, OPI),
      eb(13'h008, 5'd1, 5'd1, 3'd1),
      ei(12'h001, 5'd0, 3'd0, 5'd11, OPI),
      ej(21'h10, 5'd1),
      ei(12'h001, 5'd0, 3'd0, 5'd12, OPI),
      LOOP,
      ei(12'h001, 5'd0, 3'd0, 5'd13, OPI),
      ei(12'h001, 5'd0, 3'd0, 5'd14, OPI),
      ei(12'h000, 5'd1, 3'd0, 5'd0, 7'h67)
    };
    hold_reset();
    load_prog();
    release_reset();
    for (int c = 2; c <= 45; c++) begin
      @(posedge clk);
      #1;
      if (c == 28) check("beq_fetch", dir, 32'h28);
      if (c == 31) check("bne_fetch", dir, 32'h2C);
      if (c == 37) check("jal_fetch", dir, 32'h40);
      if (c == 43) check("jalr_fetch", dir, 32'h34);
    end
    repeat (10) @(posedge clk);
    #1;
    check("jal_link_x1", dut.rf_q[1], 32'h34);
    check("beq_skip_x10", dut.rf_q[10], 32'd0);
    check("bne_fall_x11", dut.rf_q[11], 32'd1);
    check("ret_x12", dut.rf_q[12], 32'd1);
    check("jal_skip_x13", dut.rf_q[13], 32'd0);
    check("jal_tgt_x14", dut.rf_q[14], 32'd1);

    // Reset during a word store's EXECUTE cycle
    prog = '{
      ei(12'h055, 5'd0, 3'd0, 5'd1, OPI),
      es(12'h100, 5'd1, 5'd0, 3'd2),
      LOOP
    };
    hold_reset();
    load_prog();
    poke(64, 32'hDEAD_BEEF);
    release_reset();
    repeat (5) @(posedge clk);
    #1;
    check("sw_exec_hab", {31'b0, hab_escritura}, 32'd1);
    check("sw_exec_dir", dir, 32'h100);
    check("sw_exec_dat", dat_escritura, 32'h55);
    #2 reset = 1'b0;
    #1;
    check("abort_hab", {31'b0, hab_escritura}, 32'd0);
    check("abort_dir", dir, 32'd0);
    check("abort_dat", dat_escritura, 32'd0);
    repeat (2) @(negedge clk);
    check("abort_mem", mem[64], 32'hDEAD_BEEF);
    check("abort_count", wr_n - wr0, 32'd0);
    reset = 1'b1;
    #1 check("restart_dir", dir, 32'd0);
    repeat (3) @(posedge clk);
    #1 check("restart_c4", dir, 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
